// File: rtl/crc3_serial_checker.sv
// rtl/crc3_serial_checker.sv - serial 7-bit CRC-3 (x^3+x+1) codeword checker
module crc3_serial_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_sof,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3:0]       m_data,
  output logic [2:0]       m_crc,
  output logic             m_error,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] resync_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] r;
  logic [2:0] r_step;
  logic [6:0] sh;
  logic [6:0] sh_step;
  logic [2:0] idx;
  logic       accept;

  assign s_ready = (state != HOLD);
  assign m_valid = (state == HOLD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_n = state;
    r_step  = {r[1:0], s_bit} ^ (r[2] ? 3'b011 : 3'b000);
    sh_step = {sh[5:0], s_bit};
    case (state)
      IDLE: begin
        if (accept && s_sof) state_n = SHIFT;
      end
      SHIFT: begin
        if (accept && !s_sof && idx == 3'd6) state_n = HOLD;
      end
      HOLD: begin
        if (m_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r          <= '0;
      sh         <= '0;
      idx        <= '0;
      m_data     <= '0;
      m_crc      <= '0;
      m_error    <= 1'b0;
      err_cnt    <= '0;
      resync_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept && s_sof) begin
        // A start bit always opens a fresh frame; mid-frame it abandons the old one.
        r   <= {2'b00, s_bit};
        sh  <= {6'b0, s_bit};
        idx <= 3'd1;
        if (state == SHIFT && resync_cnt != {CNT_W{1'b1}})
          resync_cnt <= resync_cnt + 1'b1;
      end else if (accept && state == SHIFT) begin
        r   <= r_step;
        sh  <= sh_step;
        idx <= idx + 3'd1;
        if (idx == 3'd6) begin
          m_data  <= sh_step[6:3];
          m_crc   <= sh_step[2:0];
          m_error <= (r_step != 3'b000);
          idx     <= 3'd0;
        end
      end
      if (state == HOLD && m_ready && m_error && err_cnt != {CNT_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_crc3_serial_checker.sv
// tb/tb_crc3_serial_checker.sv - directed and randomized bench for crc3_serial_checker
module tb_crc3_serial_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_bit, s_sof, m_ready;
  logic       s_ready, m_valid, m_error;
  logic [3:0] m_data;
  logic [2:0] m_crc;
  logic [7:0] err_cnt, resync_cnt;

  logic       s_ready2, m_valid2, m_error2;
  logic [3:0] m_data2;
  logic [2:0] m_crc2;
  logic [1:0] err_cnt2, resync_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_err = 0;
  int exp_resync = 0;

  always #5 clk = ~clk;

  crc3_serial_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_crc(m_crc), .m_error(m_error), .err_cnt(err_cnt), .resync_cnt(resync_cnt)
  );

  crc3_serial_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .s_ready(s_ready2), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
    .m_crc(m_crc2), .m_error(m_error2), .err_cnt(err_cnt2), .resync_cnt(resync_cnt2)
  );

  // Remainder by polynomial long division of the 7-bit codeword by 1011.
  function automatic logic [2:0] rem7(input logic [6:0] cw);
    logic [6:0] t;
    t = cw;
    for (int i = 6; i >= 3; i--)
      if (t[i]) t = t ^ (7'b1011 << (i - 3));
    return t[2:0];
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    s_valid = 1'b1;
    s_bit   = b;
    s_sof   = sof;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    check("accept_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] cw, input int gapmax);
    for (int i = 6; i >= 0; i--) begin
      int g;
      g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
      s_valid = 1'b0;
      s_sof   = 1'($urandom);
      s_bit   = 1'($urandom);
      repeat (g) @(posedge clk);
      #1;
      send_bit(cw[i], i == 6);
    end
  endtask

  task automatic check_frame(input logic [6:0] cw, input int hold);
    logic e;
    e = (rem7(cw) != 3'b000);
    m_ready = (hold == 0);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      check("hold_m_valid", m_valid, 1'b1);
      check("hold_s_ready", s_ready, 1'b0);
      check("m_data", m_data, cw[6:3]);
      check("m_crc", m_crc, cw[2:0]);
      check("m_error", m_error, e);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    if (e) exp_err++;
    check("post_m_valid", m_valid, 1'b0);
    check("post_s_ready", s_ready, 1'b1);
    check("err_cnt", err_cnt, sat(exp_err, 255));
    check("err_cnt_w2", err_cnt2, sat(exp_err, 3));
    check("resync_cnt", resync_cnt, sat(exp_resync, 255));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err    = 0;
    exp_resync = 0;
  endtask

  initial begin
    logic [6:0] cw;
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; m_ready = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 4'd0);
    check("rst_m_crc", m_crc, 3'd0);
    check("rst_m_error", m_error, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_resync_cnt", resync_cnt, 8'd0);
    @(posedge clk);
    #1;

    // Clean frame, back-to-back, immediate acceptance
    send_frame(7'b1101001, 0);
    check_frame(7'b1101001, 0);
    check("clean_m_error_rule", rem7(7'b1101001), 3'b000);

    // Single check-bit flip, then a clean frame
    send_frame(7'b1101011, 0);
    check_frame(7'b1101011, 0);
    send_frame(7'b0001011, 0);
    check_frame(7'b0001011, 0);

    // Gaps and five cycles of backpressure
    send_frame(7'b0000000, 3);
    check_frame(7'b0000000, 5);

    // Resync: start bit arrives on the fourth bit of a frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    exp_resync++;
    send_frame(7'b1101001, 0);
    check_frame(7'b1101001, 0);

    // Reset mid-frame followed by stray bits
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_err_cnt", err_cnt, 8'd0);
    check("midrst_resync_cnt", resync_cnt, 8'd0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'($urandom), 1'b0);
      check("stray_m_valid", m_valid, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("stray_idle_m_valid", m_valid, 1'b0);
    @(posedge clk);
    #1;
    send_frame(7'b1101001, 0);
    check_frame(7'b1101001, 0);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      cw = {4'($urandom), 3'b000};
      cw[2:0] = rem7(cw);
      cw[$urandom_range(0, 6)] ^= 1'b1;
      send_frame(cw, 1);
      check_frame(cw, 0);
    end
    check("sat_err_cnt_w2", err_cnt2, 2'd3);
    check("sat_err_cnt_w8", err_cnt, 8'd5);

    // Randomized frames with gaps, corruption and backpressure
    for (int i = 0; i < 30; i++) begin
      cw = {4'($urandom), 3'b000};
      cw[2:0] = rem7(cw);
      if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 6)] ^= 1'b1;
      send_frame(cw, 2);
      check_frame(cw, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc3_serial_checker.md
CRC3_SERIAL_CHECKER -- requirements
Module: crc3_serial_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the error and resync counters.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 s_valid  input  1  serial bit present on s_bit this cycle.
REQ-005 s_bit  input  1  serial codeword bit, MSB first.
REQ-006 s_sof  input  1  marks s_bit as codeword bit 6, the first bit of a frame; qualified by s_valid.
REQ-007 s_ready  output  1  block accepts a bit this cycle; a bit transfers only when s_valid && s_ready.
REQ-008 m_valid  output  1  decoded frame available.
REQ-009 m_ready  input  1  downstream accepts the frame; transfer occurs only when m_valid && m_ready.
REQ-010 m_data  output  4  received data nibble, codeword bits [6:3].
REQ-011 m_crc  output  3  received check bits, codeword bits [2:0].
REQ-012 m_error  output  1  codeword remainder is nonzero.
REQ-013 err_cnt  output  CNT_W  saturating count of frames delivered with m_error=1.
REQ-014 resync_cnt  output  CNT_W  saturating count of frames abandoned because s_sof arrived mid-frame.

Function
REQ-015 The codeword SHALL be {data[3:0], crc[2:0]}, with 7 bits sent bit 6 first; the generator polynomial SHALL be x^3+x+1 (4'b1011).
REQ-016 The remainder register r[2:0] SHALL update on each accepted bit b as r <= {r[1:0], b} ^ (r[2] ? 3'b011 : 3'b000).
- Bit 6 of a frame loads r <= {2'b00, b}.
REQ-017 After 7 accepted bits, m_error SHALL equal (r != 3'b000), i.e. the remainder of the full 7-bit codeword mod 1011.
REQ-018 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-019 IDLE:
- s_ready=1.
- An accepted bit with s_sof=1 starts a frame: bit index=1, go to SHIFT.
- Accepted bits with s_sof=0 SHALL be discarded silently.
REQ-020 SHIFT:
- s_ready=1.
- Each accepted bit shifts into the data/crc shift register and r, and increments the bit index.
- On acceptance of the 7th bit, go to HOLD.
- Cycles with s_valid=0 SHALL leave all state unchanged.
REQ-021 SHIFT, accepted bit with s_sof=1:
- Abandon the current frame.
- Increment resync_cnt.
- Treat this bit as bit 6 of a new frame; bit index=1, stay in SHIFT.
REQ-022 HOLD:
- s_ready=0 and m_valid=1.
- m_data, m_crc and m_error SHALL be registered and stable until the transfer.
- On m_valid && m_ready, go to IDLE on the next cycle.
REQ-023 Latency: the 7th bit accepted on the edge at cycle N SHALL give m_valid=1 in cycle N+1; m_valid SHALL NOT be combinationally dependent on s_valid.
REQ-024 err_cnt SHALL increment once per transfer with m_error=1 and SHALL saturate at 2^CNT_W-1; resync_cnt SHALL saturate likewise.
REQ-025 s_ready SHALL be a function of state only; m_ready SHALL NOT affect s_ready in the same cycle.
REQ-026 m_data, m_crc and m_error SHALL be don't-care while m_valid=0 but SHALL NOT change during HOLD.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-028 Reset SHALL set: m_valid=0, m_data=0, m_crc=0, m_error=0, r=0, bit index=0, err_cnt=0, resync_cnt=0.
REQ-029 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame without delivering it.

Verification
REQ-031 Clean frame:
- Stimulus: bits 1101001, s_sof on the first bit, back-to-back, m_ready=1.
- Required response: m_valid for one cycle, m_data=4'b1101, m_crc=3'b001, m_error=0, err_cnt=0.
REQ-032 Corrupted frame:
- Stimulus: 1101011 (single check-bit flip).
- Required response: m_error=1, err_cnt=1.
- Then stimulus: 0001011.
- Required response: m_error=0, m_crc=3'b011.
REQ-033 Gaps and backpressure:
- Stimulus: 0000000 with random s_valid gaps, m_ready held 0 for 5 cycles.
- Required response: m_valid held, outputs stable, s_ready=0 throughout HOLD; transfer on the first m_ready=1 cycle.
- Next s_sof bit accepted.
REQ-034 Resync:
- Stimulus: s_sof on bit 4 of a frame, followed by a full frame 1101001.
- Required response: resync_cnt=1, a single delivery with m_data=4'b1101 and m_error=0.
REQ-035 Reset mid-frame and stray bits:
- Stimulus: rst asserted after 3 bits, then 5 bits without s_sof, then a clean frame.
- Required response: no m_valid before the clean frame; the clean frame decodes correctly.
REQ-036 Saturation:
- Stimulus: CNT_W=2, 5 corrupted frames.
- Required response: err_cnt stops at 3.
